pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream of the 32-bit PC adder.
- Drives the adder operands (PC, 4) and consumes its sum as the sequential next PC.
- Issues one-outstanding fetch requests to instruction memory and hands fetched instructions to decode over a valid/ready interface.
- Accepts branch/jump redirects and handles squashing of in-flight fetches.

---
 rtl/pc_fetch_unit_pkg.sv | 14 +
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and state encoding for the PC / instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response and decode hand-off bundle of the fetch stage.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch FSM feeding decode; uses an external PC+4 adder.
// Optional FETCH_MISALIGN_CHECK_EN: drop misaligned redirects and flag them on fetch_misalign.
module pc_fetch_unit #(
  parameter int unsigned          XLEN        = fetch_pkg::XLEN,
  parameter int unsigned          INSTR_BYTES = fetch_pkg::INSTR_BYTES,
  parameter logic [XLEN-1:0]      RESET_PC    = XLEN'(fetch_pkg::RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         pc_add_a,
  output logic [XLEN-1:0]         pc_add_b,
  input  logic [XLEN-1:0]         pc_add_sum,
  pc_fetch_unit_if.master         bus,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    stall
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    fetch_misalign
`endif
);

  import fetch_pkg::state_e;
  import fetch_pkg::REQ;
  import fetch_pkg::WAIT;
  import fetch_pkg::HOLD;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            if_valid_q, if_valid_d;
  logic            kill_q, kill_d;
  logic            req_fire;
  logic            redir_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;

  assign redir_ok       = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign misalign_d     = misalign_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
  assign fetch_misalign = misalign_q;
`else
  assign redir_ok       = redirect_valid;
`endif

  assign pc_add_a           = pc_q;
  assign pc_add_b           = XLEN'(INSTR_BYTES);
  assign bus.imem_req_valid = !rst && (state_q == REQ) && !stall;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Next-state: redirect overrides the sequential PC and squashes whatever is in flight.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    kill_d     = kill_q;

    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          pc_d    = pc_add_sum;
          if_pc_d = pc_q;
          state_d = WAIT;
          if (redir_ok) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (kill_q || redir_ok) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            if_instr_d = bus.imem_resp_data;
            if_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (redir_ok) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redir_ok || bus.if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (redir_ok) pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      kill_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      kill_q     <= kill_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 1-deep memory model and an external PC adder.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_add_a, pc_add_b, pc_add_sum;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_add_a       (pc_add_a),
    .pc_add_b       (pc_add_b),
    .pc_add_sum     (pc_add_sum),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  assign pc_add_sum = pc_add_a + pc_add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_cnt = 0;
  int          del_cnt = 0;
  logic [31:0] req_log [64];
  logic [31:0] del_pc  [64];
  logic [31:0] del_ins [64];
  int          mem_cnt = 0;
  logic [31:0] mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory: response data is {addr[15:0], 16'hC0DE}, seen by the DUT two edges after accept.
  always @(posedge clk) begin
    bus.imem_resp_valid <= 1'b0;
    if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= {mem_addr[15:0], 16'hC0DE};
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mem_cnt  <= 1;
      mem_addr <= bus.imem_req_addr;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.imem_req_valid && bus.imem_req_ready && req_cnt < 64) begin
      req_log[req_cnt] = bus.imem_req_addr;
      req_cnt++;
    end
    if (!rst && bus.if_valid && bus.if_ready && del_cnt < 64) begin
      del_pc[del_cnt]  = bus.if_pc;
      del_ins[del_cnt] = bus.if_instr;
      del_cnt++;
    end
  end

  task automatic wait_req(input int n);
    for (int k = 0; k < 100 && req_cnt < n; k++) @(negedge clk);
    check("wait_req", 32'(req_cnt), 32'(n));
  endtask

  task automatic wait_del(input int n);
    for (int k = 0; k < 100 && del_cnt < n; k++) @(negedge clk);
    check("wait_del", 32'(del_cnt), 32'(n));
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 100 && bus.if_valid !== 1'b1; k++) @(negedge clk);
    check("wait_if_valid", 32'(bus.if_valid), 32'd1);
  endtask

  int rbase, dbase;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_if_valid",  32'(bus.if_valid), 32'd0);
    check("rst_if_pc",     bus.if_pc, 32'h0);
    check("rst_if_instr",  bus.if_instr, 32'h0);
    check("rst_pc",        pc_add_a, 32'h0);
    check("add_b",         pc_add_b, 32'h4);
    rst = 1'b0;

    // Straight-line fetch, then decode backpressure on the 0x4 instruction
    wait_del(1);
    bus.if_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_if_pc",    bus.if_pc, 32'h4);
      check("bp_if_instr", bus.if_instr, 32'h0004_C0DE);
      check("bp_no_req",   32'(bus.imem_req_valid), 32'd0);
    end
    check("bp_req_cnt", 32'(req_cnt), 32'd2);
    bus.if_ready = 1'b1;
    wait_req(3);
    check("seq_addr0", req_log[0], 32'h0);
    check("seq_addr1", req_log[1], 32'h4);
    check("seq_addr2", req_log[2], 32'h8);
    check("seq_pc0",   del_pc[0],  32'h0);
    check("seq_ins0",  del_ins[0], 32'h0000_C0DE);
    check("seq_pc1",   del_pc[1],  32'h4);
    check("seq_ins1",  del_ins[1], 32'h0004_C0DE);

    // Redirect while 0x8 is outstanding: its response must be dropped
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_kill_if_valid", 32'(bus.if_valid), 32'd0);
    wait_req(5);
    check("rw_addr3", req_log[3], 32'h100);
    check("rw_addr4", req_log[4], 32'h104);
    check("rw_del_cnt", 32'(del_cnt), 32'd3);
    check("rw_pc2",   del_pc[2],  32'h100);
    check("rw_ins2",  del_ins[2], 32'h0100_C0DE);

    // Redirect in HOLD to 0x10, then redirect to 0x200 on the very accept of 0x10
    bus.if_ready = 1'b0;
    wait_valid();
    check("hold_if_pc", bus.if_pc, 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    check("hold_redir_if_valid", 32'(bus.if_valid), 32'd0);
    check("hold_redir_addr", bus.imem_req_addr, 32'h10);
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    wait_req(7);
    check("ra_addr5", req_log[5], 32'h10);
    check("ra_addr6", req_log[6], 32'h200);
    wait_del(4);
    check("ra_pc3",  del_pc[3],  32'h200);
    check("ra_ins3", del_ins[3], 32'h0200_C0DE);

    // Stall for 3 cycles while redirecting to the top of the address space, then wrap
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    check("stall_pc", pc_add_a, 32'hFFFF_FFFC);
    check("stall_req_cnt", 32'(req_cnt), 32'd7);
    stall = 1'b0;
    wait_req(8);
    check("wrap_addr7", req_log[7], 32'hFFFF_FFFC);
    check("wrap_pc", pc_add_a, 32'h0);
    wait_del(5);
    check("wrap_pc4",  del_pc[4],  32'hFFFF_FFFC);
    check("wrap_ins4", del_ins[4], 32'hFFFC_C0DE);
    wait_req(9);
    check("wrap_addr8", req_log[8], 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis_flag", 32'(fetch_misalign), 32'd1);
    wait_req(10);
    check("mis_addr9", req_log[9], 32'h4);
    check("mis_sticky", 32'(fetch_misalign), 32'd1);
`endif

    // Reset with a fetch outstanding; the late response must be ignored
    rst = 1'b1;
    @(negedge clk);
    check("mrst_if_valid", 32'(bus.if_valid), 32'd0);
    check("mrst_pc",       pc_add_a, 32'h0);
    check("mrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mrst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    rst = 1'b0;
    rbase = req_cnt;
    dbase = del_cnt;
    wait_req(rbase + 1);
    check("mrst_addr", req_log[rbase], 32'h0);
    wait_del(dbase + 1);
    check("mrst_del_pc",  del_pc[dbase],  32'h0);
    check("mrst_del_ins", del_ins[dbase], 32'h0000_C0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
